// File: rtl/decode_issue_stage.sv
// Decode/issue stage: register file with write-through reads, a 2-bit pending-write
// scoreboard, optional EX-to-decode forwarding and a single issue register with backpressure.
module decode_issue_stage #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int FORWARD  = 1,
  localparam int RW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [RW-1:0]   in_rs1,
  input  logic [RW-1:0]   in_rs2,
  input  logic [RW-1:0]   in_rd,
  input  logic            in_reg_write,
  input  logic            in_is_load,
  input  logic            wb_enable,
  input  logic [RW-1:0]   wb_idx,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_jump_addr,
  output logic [RW-1:0]   out_rd,
  output logic            out_reg_write,
  output logic            out_is_load,
  output logic            out_fwd1,
  output logic            out_fwd2,
  output logic [31:0]     stall_count
);

  logic [XLEN-1:0] regs         [NUM_REGS];
  logic [1:0]      pending      [NUM_REGS];
  logic [1:0]      pending_next [NUM_REGS];

  // Out-of-range indices behave exactly like x0.
  function automatic logic [RW-1:0] map_idx(input logic [RW-1:0] idx);
    return (int'(idx) < NUM_REGS) ? idx : '0;
  endfunction

  logic [RW-1:0]   rs1, rs2, rd, wb_ix;
  logic            wb_hit1, wb_hit2, fwd1, fwd2, hazard1, hazard2;
  logic            issue, flush_drop;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [2:0]      cnt;

  assign rs1   = map_idx(in_rs1);
  assign rs2   = map_idx(in_rs2);
  assign rd    = map_idx(in_rd);
  assign wb_ix = map_idx(wb_idx);

  // A writeback landing this cycle satisfies one pending write, so a consumer
  // waiting only on that write may issue with the write-through value.
  always_comb begin
    wb_hit1 = wb_enable && (wb_ix == rs1) && (rs1 != '0);
    wb_hit2 = wb_enable && (wb_ix == rs2) && (rs2 != '0);
    rs1_val = (rs1 == '0) ? '0 : (wb_hit1 ? wb_data : regs[rs1]);
    rs2_val = (rs2 == '0) ? '0 : (wb_hit2 ? wb_data : regs[rs2]);
    fwd1 = (FORWARD != 0) && (rs1 != '0) && (pending[rs1] != 2'd0) && out_valid &&
           out_reg_write && !out_is_load && (out_rd == rs1);
    fwd2 = (FORWARD != 0) && (rs2 != '0) && (pending[rs2] != 2'd0) && out_valid &&
           out_reg_write && !out_is_load && (out_rd == rs2);
    hazard1 = (rs1 != '0) && !fwd1 && (pending[rs1] > {1'b0, wb_hit1});
    hazard2 = (rs2 != '0) && !fwd2 && (pending[rs2] > {1'b0, wb_hit2});
    in_ready = !flush && !hazard1 && !hazard2 && (!out_valid || out_ready) &&
               (pending[rd] != 2'd3);
    issue = in_valid && in_ready;
    flush_drop = flush && out_valid && out_reg_write && !out_ready && (out_rd != '0);
  end

  // Decrements never underflow: a writeback to a register with nothing pending is a no-op.
  always_comb begin
    cnt = '0;
    pending_next[0] = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      cnt = {1'b0, pending[i]};
      if (issue && in_reg_write && (int'(rd) == i)) cnt = cnt + 3'd1;
      if (wb_enable && (int'(wb_ix) == i) && (cnt != 3'd0)) cnt = cnt - 3'd1;
      if (flush_drop && (int'(out_rd) == i) && (cnt != 3'd0)) cnt = cnt - 3'd1;
      pending_next[i] = cnt[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wb_enable && (wb_ix != '0)) regs[wb_ix] <= wb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_rs1_val   <= '0;
      out_rs2_val   <= '0;
      out_imm       <= '0;
      out_jump_addr <= '0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      out_is_load   <= 1'b0;
      out_fwd1      <= 1'b0;
      out_fwd2      <= 1'b0;
      stall_count   <= '0;
      for (int i = 0; i < NUM_REGS; i++) pending[i] <= '0;
    end else begin
      pending <= pending_next;
      if (issue) begin
        out_valid     <= 1'b1;
        out_rs1_val   <= rs1_val;
        out_rs2_val   <= rs2_val;
        out_imm       <= in_imm;
        out_jump_addr <= in_pc + in_imm;
        out_rd        <= rd;
        out_reg_write <= in_reg_write;
        out_is_load   <= in_is_load;
        out_fwd1      <= fwd1;
        out_fwd2      <= fwd2;
      end else if (flush || out_ready) begin
        out_valid <= 1'b0;
      end
      if (in_valid && !in_ready && !flush && (stall_count != 32'hFFFF_FFFF))
        stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Bench for decode_issue_stage: a FORWARD=1 and a FORWARD=0 instance share stimulus and are
// checked against a per-instance behavioural model, with directed scenarios and random traffic.
module tb_decode_issue_stage;
  localparam int XLEN = 32;
  localparam int NR   = 32;
  localparam int RW   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, flush, in_valid, out_ready, in_reg_write, in_is_load, wb_enable;
  logic [XLEN-1:0] in_pc, in_imm, wb_data;
  logic [RW-1:0]   in_rs1, in_rs2, in_rd, wb_idx;

  wire [1:0]            in_ready, out_valid, out_reg_write, out_is_load, out_fwd1, out_fwd2;
  wire [1:0][XLEN-1:0]  out_rs1_val, out_rs2_val, out_imm, out_jump_addr;
  wire [1:0][RW-1:0]    out_rd;
  wire [1:0][31:0]      stall_count;

  // Instance 0 forwards from EX, instance 1 waits for writeback.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    decode_issue_stage #(.XLEN(XLEN), .NUM_REGS(NR), .FORWARD(g == 0 ? 1 : 0)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready[g]),
      .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .in_reg_write(in_reg_write), .in_is_load(in_is_load),
      .wb_enable(wb_enable), .wb_idx(wb_idx), .wb_data(wb_data),
      .out_valid(out_valid[g]), .out_ready(out_ready),
      .out_rs1_val(out_rs1_val[g]), .out_rs2_val(out_rs2_val[g]),
      .out_imm(out_imm[g]), .out_jump_addr(out_jump_addr[g]), .out_rd(out_rd[g]),
      .out_reg_write(out_reg_write[g]), .out_is_load(out_is_load[g]),
      .out_fwd1(out_fwd1[g]), .out_fwd2(out_fwd2[g]), .stall_count(stall_count[g])
    );
  end

  typedef struct {
    logic [XLEN-1:0] rs1, rs2, imm, jaddr;
    logic [RW-1:0]   rd;
    logic            rw, ld, f1, f2;
  } issued_t;

  logic [XLEN-1:0] m_regs [NR];
  int              m_pend [2][NR];
  bit              m_ov   [2];
  issued_t         m_out  [2];
  logic [31:0]     m_stall[2];
  bit              exp_ready [2];
  logic            obs_ready [2];
  int vectors = 0;
  int miscompares = 0;

  // Operand read as seen by decode this cycle, including a same-cycle writeback.
  function automatic logic [XLEN-1:0] read_val(input int idx);
    if (idx == 0) return '0;
    if (wb_enable && int'(wb_idx) == idx) return wb_data;
    return m_regs[idx];
  endfunction

  function automatic bit can_fwd(input int k, input int idx);
    return k == 0 && idx != 0 && m_pend[k][idx] > 0 && m_ov[k] && m_out[k].rw &&
           !m_out[k].ld && int'(m_out[k].rd) == idx;
  endfunction

  function automatic bit src_clear(input int k, input int idx);
    int remaining;
    if (idx == 0 || m_pend[k][idx] == 0 || can_fwd(k, idx)) return 1'b1;
    remaining = m_pend[k][idx] - ((wb_enable && int'(wb_idx) == idx) ? 1 : 0);
    return remaining <= 0;
  endfunction

  function automatic bit model_ready(input int k);
    return !flush && src_clear(k, int'(in_rs1)) && src_clear(k, int'(in_rs2)) &&
           (!m_ov[k] || out_ready) && m_pend[k][int'(in_rd)] != 3;
  endfunction

  // Advance one clock: sample in_ready mid-cycle, update the model, return just after the edge.
  task automatic step();
    bit iss [2];
    bit f1 [2];
    bit f2 [2];
    logic [XLEN-1:0] v1, v2;
    @(negedge clk);
    v1 = read_val(int'(in_rs1));
    v2 = read_val(int'(in_rs2));
    for (int k = 0; k < 2; k++) begin
      exp_ready[k] = model_ready(k);
      obs_ready[k] = in_ready[k];
      iss[k] = in_valid && exp_ready[k];
      f1[k] = can_fwd(k, int'(in_rs1));
      f2[k] = can_fwd(k, int'(in_rs2));
    end
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int i = 0; i < NR; i++) m_pend[k][i] = 0;
        m_ov[k] = 1'b0;
        m_out[k] = '{default: '0};
        m_stall[k] = '0;
      end else begin
        if (iss[k] && in_reg_write && in_rd != 0) m_pend[k][in_rd]++;
        if (wb_enable && wb_idx != 0 && m_pend[k][wb_idx] > 0) m_pend[k][wb_idx]--;
        if (flush && m_ov[k] && m_out[k].rw && !out_ready && m_out[k].rd != 0 &&
            m_pend[k][m_out[k].rd] > 0) m_pend[k][m_out[k].rd]--;
        if (in_valid && !exp_ready[k] && !flush && m_stall[k] != 32'hFFFF_FFFF) m_stall[k]++;
        if (iss[k]) begin
          m_out[k] = '{v1, v2, in_imm, in_pc + in_imm, in_rd, in_reg_write, in_is_load,
                       f1[k], f2[k]};
          m_ov[k] = 1'b1;
        end else if (flush || out_ready) begin
          m_ov[k] = 1'b0;
        end
      end
    end
    if (!rst && wb_enable && wb_idx != 0) m_regs[wb_idx] = wb_data;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_imm = '0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_reg_write = 1'b0; in_is_load = 1'b0;
    wb_enable = 1'b0; wb_idx = '0; wb_data = '0; out_ready = 1'b1;
  endtask

  task automatic drive_instr(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                             input int s1, input int s2, input int d, input bit w, input bit ld);
    in_valid = 1'b1; in_pc = pc; in_imm = imm;
    in_rs1 = RW'(s1); in_rs2 = RW'(s2); in_rd = RW'(d); in_reg_write = w; in_is_load = ld;
  endtask

  task automatic preload_regs();
    drive_idle();
    for (int i = 1; i < NR; i++) begin
      wb_enable = 1'b1; wb_idx = RW'(i); wb_data = $urandom;
      step();
    end
    drive_idle();
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NR; i++) m_pend[k][i] = 0;
      m_ov[k] = 1'b0; m_out[k] = '{default: '0}; m_stall[k] = '0;
    end
    drive_idle();
    rst = 1'b1; in_valid = 1'b1; in_rs1 = 5'd4; in_rd = 5'd2; in_reg_write = 1'b1;
    step(); step();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (out_valid[k] !== 1'b0 || stall_count[k] !== 32'd0 || out_rd[k] !== '0 ||
          out_rs1_val[k] !== '0 || out_jump_addr[k] !== '0 || out_fwd1[k] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_state dut%0d got valid=%b stall=%h rd=%h rs1=%h ja=%h want all zero",
                 k, out_valid[k], stall_count[k], out_rd[k], out_rs1_val[k], out_jump_addr[k]);
      end
    end
    drive_idle();
    step();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (obs_ready[k] !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL reset_ready dut%0d got %b want 1", k, obs_ready[k]);
      end
    end
  endtask

  task automatic test_regread();
    drive_idle();
    wb_enable = 1'b1; wb_idx = 5'd5; wb_data = 32'h1234;
    step();
    drive_idle();
    drive_instr(32'h1000, 32'hFFFF_FFFC, 5, 0, 0, 0, 0);
    step();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (obs_ready[k] !== 1'b1 || out_valid[k] !== 1'b1 || out_rs1_val[k] !== 32'h1234 ||
          out_fwd1[k] !== 1'b0 || out_rs2_val[k] !== 32'h0 || out_jump_addr[k] !== 32'h0FFC ||
          out_imm[k] !== 32'hFFFF_FFFC) begin
        miscompares++;
        $display("[TB] FAIL regread dut%0d got rdy=%b v=%b rs1=%h fwd=%b rs2=%h ja=%h want 1 1 1234 0 0 ffc",
                 k, obs_ready[k], out_valid[k], out_rs1_val[k], out_fwd1[k], out_rs2_val[k],
                 out_jump_addr[k]);
      end
    end
    drive_idle();
    step();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (out_valid[k] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL drain_valid dut%0d got %b want 0", k, out_valid[k]);
      end
    end
  endtask

  task automatic test_forward();
    drive_idle();
    drive_instr(32'h2000, 32'h8, 0, 0, 3, 1, 0);
    step();
    drive_instr(32'h2004, 32'h0, 3, 0, 0, 0, 0);
    step();
    vectors++;
    if (obs_ready[0] !== 1'b1 || out_valid[0] !== 1'b1 || out_fwd1[0] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL fwd_issue dut0 got rdy=%b v=%b fwd1=%b want 1 1 1",
               obs_ready[0], out_valid[0], out_fwd1[0]);
    end
    vectors++;
    if (obs_ready[1] !== 1'b0 || out_valid[1] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL nofwd_stall dut1 got rdy=%b v=%b want 0 0", obs_ready[1], out_valid[1]);
    end
    step();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (obs_ready[k] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL wait_wb3 dut%0d got rdy=%b want 0", k, obs_ready[k]);
      end
    end
    wb_enable = 1'b1; wb_idx = 5'd3; wb_data = 32'hCAFE_0003;
    step();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (obs_ready[k] !== 1'b1 || out_rs1_val[k] !== 32'hCAFE_0003 || out_fwd1[k] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL wb3_issue dut%0d got rdy=%b rs1=%h fwd1=%b want 1 cafe0003 0",
                 k, obs_ready[k], out_rs1_val[k], out_fwd1[k]);
      end
    end
    drive_idle();
    step();
  endtask

  task automatic test_load_use();
    logic [31:0] base [2];
    drive_idle();
    drive_instr(32'h3000, 32'h0, 0, 0, 7, 1, 1);
    step();
    base[0] = m_stall[0]; base[1] = m_stall[1];
    drive_instr(32'h3004, 32'h0, 0, 7, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs_ready[k] !== 1'b0 || stall_count[k] !== base[k] + 32'(i)) begin
          miscompares++;
          $display("[TB] FAIL load_use_stall dut%0d cyc%0d got rdy=%b cnt=%0d want 0 %0d",
                   k, i, obs_ready[k], stall_count[k], base[k] + 32'(i));
        end
      end
    end
    wb_enable = 1'b1; wb_idx = 5'd7; wb_data = 32'h7777_0007;
    step();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (obs_ready[k] !== 1'b1 || out_valid[k] !== 1'b1 || out_rs2_val[k] !== 32'h7777_0007 ||
          stall_count[k] !== base[k] + 32'd3) begin
        miscompares++;
        $display("[TB] FAIL load_use_issue dut%0d got rdy=%b v=%b rs2=%h cnt=%0d want 1 1 77770007 %0d",
                 k, obs_ready[k], out_valid[k], out_rs2_val[k], stall_count[k], base[k] + 32'd3);
      end
    end
    drive_idle();
    step();
  endtask

  task automatic test_backpressure();
    logic [XLEN-1:0] e1, e2;
    logic [31:0] base [2];
    e1 = m_regs[1]; e2 = m_regs[2];
    drive_idle();
    drive_instr(32'h4000, 32'h10, 1, 2, 0, 0, 0);
    step();
    base[0] = m_stall[0]; base[1] = m_stall[1];
    drive_instr(32'h4004, 32'h20, 4, 0, 0, 0, 0);
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs_ready[k] !== 1'b0 || out_valid[k] !== 1'b1 || out_rs1_val[k] !== e1 ||
            out_rs2_val[k] !== e2 || out_imm[k] !== 32'h10 || out_jump_addr[k] !== 32'h4010) begin
          miscompares++;
          $display("[TB] FAIL hold dut%0d cyc%0d got rdy=%b v=%b rs1=%h rs2=%h imm=%h ja=%h want 0 1 %h %h 10 4010",
                   k, i, obs_ready[k], out_valid[k], out_rs1_val[k], out_rs2_val[k], out_imm[k],
                   out_jump_addr[k], e1, e2);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (stall_count[k] !== base[k] + 32'd4) begin
        miscompares++;
        $display("[TB] FAIL hold_stalls dut%0d got %0d want %0d", k, stall_count[k], base[k] + 32'd4);
      end
    end
    out_ready = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (obs_ready[k] !== 1'b1 || out_imm[k] !== 32'h20) begin
        miscompares++;
        $display("[TB] FAIL release dut%0d got rdy=%b imm=%h want 1 20", k, obs_ready[k], out_imm[k]);
      end
    end
    drive_idle();
    step();
  endtask

  task automatic test_flush();
    logic [XLEN-1:0] e9;
    e9 = m_regs[9];
    drive_idle();
    drive_instr(32'h5000, 32'h4, 0, 0, 9, 1, 0);
    step();
    drive_idle();
    out_ready = 1'b0; flush = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (out_valid[k] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL flush_valid dut%0d got %b want 0", k, out_valid[k]);
      end
    end
    drive_idle();
    drive_instr(32'h5004, 32'h0, 9, 0, 0, 0, 0);
    step();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (obs_ready[k] !== 1'b1 || out_valid[k] !== 1'b1 || out_fwd1[k] !== 1'b0 ||
          out_rs1_val[k] !== e9) begin
        miscompares++;
        $display("[TB] FAIL flush_reissue dut%0d got rdy=%b v=%b fwd1=%b rs1=%h want 1 1 0 %h",
                 k, obs_ready[k], out_valid[k], out_fwd1[k], out_rs1_val[k], e9);
      end
    end
    drive_idle();
    step();
  endtask

  task automatic test_reset_mid_stall();
    logic [XLEN-1:0] e7;
    drive_idle();
    drive_instr(32'h6000, 32'h0, 0, 0, 7, 1, 1);
    step();
    e7 = m_regs[7];
    drive_instr(32'h6004, 32'h0, 0, 7, 0, 0, 0);
    step(); step();
    rst = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (out_valid[k] !== 1'b0 || stall_count[k] !== 32'd0 || out_rs2_val[k] !== '0) begin
        miscompares++;
        $display("[TB] FAIL rst_mid_stall dut%0d got v=%b cnt=%0d rs2=%h want 0 0 0",
                 k, out_valid[k], stall_count[k], out_rs2_val[k]);
      end
    end
    rst = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (obs_ready[k] !== 1'b1 || out_valid[k] !== 1'b1 || out_rs2_val[k] !== e7) begin
        miscompares++;
        $display("[TB] FAIL post_rst_issue dut%0d got rdy=%b v=%b rs2=%h want 1 1 %h",
                 k, obs_ready[k], out_valid[k], out_rs2_val[k], e7);
      end
    end
    drive_idle();
    step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      drive_idle();
      rst          = ($urandom_range(0, 99) == 0);
      flush        = ($urandom_range(0, 19) == 0);
      in_valid     = ($urandom_range(0, 3) != 0);
      in_pc        = $urandom;
      in_imm       = $urandom;
      in_rs1       = RW'($urandom_range(0, 7));
      in_rs2       = RW'($urandom_range(0, 7));
      in_rd        = RW'($urandom_range(0, 7));
      in_reg_write = ($urandom_range(0, 2) != 0);
      in_is_load   = ($urandom_range(0, 3) == 0);
      wb_enable    = ($urandom_range(0, 2) == 0);
      wb_idx       = RW'($urandom_range(0, 7));
      wb_data      = $urandom;
      out_ready    = ($urandom_range(0, 3) != 0);
      step();
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs_ready[k] !== exp_ready[k] || out_valid[k] !== m_ov[k]) begin
          miscompares++;
          $display("[TB] FAIL rand_handshake dut%0d cyc%0d got rdy=%b v=%b want %b %b",
                   k, n, obs_ready[k], out_valid[k], exp_ready[k], m_ov[k]);
        end
        vectors++;
        if (out_rs1_val[k] !== m_out[k].rs1 || out_rs2_val[k] !== m_out[k].rs2 ||
            out_imm[k] !== m_out[k].imm || out_jump_addr[k] !== m_out[k].jaddr) begin
          miscompares++;
          $display("[TB] FAIL rand_data dut%0d cyc%0d got %h %h %h %h want %h %h %h %h",
                   k, n, out_rs1_val[k], out_rs2_val[k], out_imm[k], out_jump_addr[k],
                   m_out[k].rs1, m_out[k].rs2, m_out[k].imm, m_out[k].jaddr);
        end
        vectors++;
        if (out_rd[k] !== m_out[k].rd || out_reg_write[k] !== m_out[k].rw ||
            out_is_load[k] !== m_out[k].ld || out_fwd1[k] !== m_out[k].f1 ||
            out_fwd2[k] !== m_out[k].f2) begin
          miscompares++;
          $display("[TB] FAIL rand_ctrl dut%0d cyc%0d got rd=%0d w=%b ld=%b f=%b%b want %0d %b %b %b%b",
                   k, n, out_rd[k], out_reg_write[k], out_is_load[k], out_fwd1[k], out_fwd2[k],
                   m_out[k].rd, m_out[k].rw, m_out[k].ld, m_out[k].f1, m_out[k].f2);
        end
        vectors++;
        if (stall_count[k] !== m_stall[k]) begin
          miscompares++;
          $display("[TB] FAIL rand_stall dut%0d cyc%0d got %0d want %0d", k, n, stall_count[k], m_stall[k]);
        end
      end
    end
    drive_idle();
    step();
  endtask

  initial begin
    drive_idle();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    test_reset();
    preload_regs();
    test_regread();
    test_forward();
    test_load_use();
    test_backpressure();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decode_issue_stage.md
DECODE_ISSUE_STAGE -- requirements
Module: decode_issue_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath/PC width.
REQ-002 Parameter NUM_REGS, default 32 (16 for RV32E), GPR count; RW = clog2(NUM_REGS).
REQ-003 Parameter FORWARD, default 1; 1 = EX-to-decode forwarding enabled, 0 = stall until writeback.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 flush  in  1  kill instruction in output register and reject current input.
REQ-007 in_valid  in  1  decoded instruction present.
REQ-008 in_ready  out  1  instruction accepted this cycle (comb).
REQ-009 in_pc  in  XLEN  instruction PC.
REQ-010 in_imm  in  XLEN  sign-extended immediate.
REQ-011 in_rs1, in_rs2  in  RW each  source indices.
REQ-012 in_rd  in  RW  destination index.
REQ-013 in_reg_write  in  1  instruction writes rd.
REQ-014 in_is_load  in  1  instruction is a load.
REQ-015 wb_enable  in  1  writeback strobe.
REQ-016 wb_idx  in  RW  writeback index.
REQ-017 wb_data  in  XLEN  writeback data.
REQ-018 out_valid  out  1  issued instruction held.
REQ-019 out_ready  in  1  downstream accepts when out_valid.
REQ-020 out_rs1_val, out_rs2_val  out  XLEN each  operand values.
REQ-021 out_imm, out_jump_addr  out  XLEN each  immediate; in_pc + in_imm mod 2^XLEN.
REQ-022 out_rd  out  RW; out_reg_write, out_is_load  out  1 each.
REQ-023 out_fwd1, out_fwd2  out  1 each  operand must take EX result.
REQ-024 stall_count  out  32  saturating count of stall cycles.

Function
REQ-025 Internal NUM_REGS x XLEN register file; x0 reads 0, writes to x0 ignored.
REQ-026 Read with write-through: wb_enable && wb_idx==rsX && rsX!=0 returns wb_data same cycle.
REQ-027 Scoreboard: 2-bit pending counter per register; +1 on issue of writer with rd!=0; -1 on wb_enable with wb_idx!=0; simultaneous +1/-1 on same register = no change.
REQ-028 Issue = in_valid && in_ready; output register loads at that edge (latency 1), out_valid set.
REQ-029 in_ready = !flush && !hazard && (!out_valid || out_ready) && pending[in_rd]!=3.
REQ-030 hazard per used source rsX!=0 with pending[rsX]>0: FORWARD=1 and rsX==out_rd and out_valid && out_reg_write && !out_is_load -> no stall, set out_fwdX at issue; otherwise stall.
REQ-031 FORWARD=0: any pending source stalls; out_fwd1/out_fwd2 always 0.
REQ-032 out_valid && !out_ready: all out_* held stable; in_ready=0.
REQ-033 out_valid && out_ready && no issue: out_valid clears next edge.
REQ-034 flush: out_valid cleared next edge; if held instruction was a writer not taken this cycle (out_ready=0), decrement pending[out_rd].
REQ-035 stall_count +1 each cycle in_valid && !in_ready && !flush; holds at 0xFFFFFFFF.
REQ-036 Index >= NUM_REGS on any source/rd: treated as x0.

Reset
REQ-037 rst: out_valid=0, all out_* = 0, all pending=0, stall_count=0; register file contents unchanged; rst overrides flush, issue and writeback.
REQ-038 rst mid-stall: in_ready reflects cleared scoreboard the cycle after rst deasserts.

Verification
REQ-039 Write x5=0x1234 via wb, issue rs1=5 -> out_rs1_val=0x1234 one cycle later, out_fwd1=0.
REQ-040 FORWARD=1: issue ALU writer rd=3, next issue rs1=3 -> no stall, out_fwd1=1; FORWARD=0 same stimulus -> in_ready=0 until wb_idx=3.
REQ-041 Load rd=7 then consumer rs2=7 -> stall, stall_count increments per cycle, issue the cycle wb_idx=7 arrives with write-through data.
REQ-042 out_ready=0 for 4 cycles with valid outputs -> all out_* stable, in_ready=0, stall_count +4.
REQ-043 Flush with held writer rd=9, out_ready=0 -> out_valid=0 next cycle, pending[9] returns to 0, rs1=9 issues without stall.
REQ-044 rst asserted during load-use stall -> outputs and stall_count zero next cycle, consumer issues after rst deasserts.
